tremolo_multi: RTL and testbench

//  Multi-channel amplitude-modulation (tremolo) effect for the audio codec path.
//  A per-sample LFO (sine/triangle/square) scales every channel by a unsigned Q0.16 gain.
//  The LFO rate advances once per audio frame, not per clock. The depth is programmable.
//  One shared multiplier is time-multiplexed across channels. Sits between codec RX and TX.

---
 rtl/tremolo_pkg.sv | 46 ++++
 rtl/tremolo_sine_lut.sv | 35 +++
 rtl/tremolo_multi.sv | 164 ++++++++++++++++
 tb/tb_tremolo_multi.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tremolo_pkg.sv
// rtl/tremolo_pkg.sv - shared encodings, FSM states and quarter-wave sine table
package tremolo_pkg;

  typedef enum logic [1:0] {
    SHAPE_SINE = 2'd0,
    SHAPE_TRI  = 2'd1,
    SHAPE_SQR  = 2'd2,
    SHAPE_NONE = 2'd3
  } shape_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUT,
    ST_GAIN,
    ST_MAC,
    ST_DONE
  } state_e;

  localparam logic [15:0] GAIN_ONE = 16'hffff;
  localparam logic [15:0] LFO_MID  = 16'h8000;

  // Entry i = round(32767*sin(2*pi*i/1024)), evaluated with a Q30 Taylor series
  function automatic logic [4095:0] build_sine_tab();
    logic [4095:0] tab;
    longint x;
    longint term;
    longint sum;
    tab = '0;
    for (int i = 0; i < 256; i++) begin
      x    = (64'sd3373259426 * longint'(i)) / 64'sd512;
      term = x;
      sum  = x;
      for (int k = 1; k < 8; k++) begin
        term = (term * x) >>> 30;
        term = (term * x) >>> 30;
        term = -term / longint'((2 * k) * (2 * k + 1));
        sum  = sum + term;
      end
      tab[i*16 +: 16] = 16'((64'sd32767 * sum + 64'sd536870912) >>> 30);
    end
    return tab;
  endfunction

  localparam logic [4095:0] SINE_TAB = build_sine_tab();

endpackage

// File: rtl/tremolo_sine_lut.sv
// rtl/tremolo_sine_lut.sv - registered sine LFO from a quarter-wave table
module tremolo_sine_lut
  import tremolo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  phase,
  output logic [15:0] lfo
);

  logic [1:0]  quad;
  logic [7:0]  idx;
  logic [8:0]  midx;
  logic [14:0] mag;

  assign quad = phase[9:8];
  assign idx  = phase[7:0];

  // Odd quadrants read the table backwards; index 256 is the peak, just past the table end
  always_comb begin
    midx = quad[0] ? (9'd256 - {1'b0, idx}) : {1'b0, idx};
    mag  = midx[8] ? 15'h7fff : SINE_TAB[{midx[7:0], 4'b0000} +: 15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfo <= '0;
    end else if (quad[1]) begin
      lfo <= LFO_MID - {1'b0, mag};
    end else begin
      lfo <= LFO_MID + {1'b0, mag};
    end
  end

endmodule

// File: rtl/tremolo_multi.sv
// rtl/tremolo_multi.sv - multi-channel tremolo with frame-rate LFO and one shared multiplier
module tremolo_multi
  import tremolo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int PHASE_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] audio_in,
  input  logic [PHASE_W-1:0]           fcw,
  input  logic [7:0]                   depth,
  input  logic [1:0]                   shape,
  input  logic                         bypass,
  input  logic                         overrun_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0] audio_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [15:0]                  lfo_dbg
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BUS_W = NUM_CH * DATA_WIDTH;

  state_e                       state;
  state_e                       state_nxt;
  logic                         accept;
  logic                         last_ch;
  logic [BUS_W-1:0]             x_lat;
  logic [7:0]                   depth_lat;
  shape_e                       shape_lat;
  logic                         bypass_lat;
  logic [PHASE_W-1:0]           phase;
  logic [16:0]                  ptop;
  logic [16:0]                  plat;
  logic [15:0]                  sine_lfo;
  logic [15:0]                  lfo_sel;
  logic [15:0]                  inv;
  logic [15:0]                  mod_amt;
  logic [7:0]                   mod_lsb_unused;
  logic [15:0]                  gain;
  logic [15:0]                  gain_nxt;
  logic [CH_W-1:0]              ch;
  logic signed [DATA_WIDTH-1:0] x_ch;
  logic signed [DATA_WIDTH-1:0] y;
  logic [15:0]                  frac_unused;
  logic signed [DATA_WIDTH+15:0] x_ext;
  logic signed [DATA_WIDTH+15:0] g_ext;

  // Only the top 17 phase bits ever shape the LFO; narrow accumulators are left-aligned
  if (PHASE_W >= 17) begin : g_ptop_wide
    assign ptop = phase[PHASE_W-1 -: 17];
  end else begin : g_ptop_narrow
    assign ptop = {phase, {(17-PHASE_W){1'b0}}};
  end

  assign accept  = (state == ST_IDLE) && sample_valid;
  assign last_ch = (ch == CH_W'(NUM_CH - 1));

  tremolo_sine_lut u_sine (
    .clk   (clk),
    .rst   (rst),
    .phase (plat[16:7]),
    .lfo   (sine_lfo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sample_valid) state_nxt = ST_LUT;
      ST_LUT:  state_nxt = ST_GAIN;
      ST_GAIN: state_nxt = ST_MAC;
      ST_MAC:  if (last_ch) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_LUT) || (state == ST_GAIN) || (state == ST_MAC);
    out_valid = (state == ST_DONE);
  end

  always_comb begin
    case (shape_lat)
      SHAPE_SINE: lfo_sel = sine_lfo;
      SHAPE_TRI:  lfo_sel = plat[16] ? ~plat[15:0] : plat[15:0];
      SHAPE_SQR:  lfo_sel = plat[16] ? 16'h0000 : 16'hffff;
      default:    lfo_sel = GAIN_ONE;
    endcase
    inv                       = GAIN_ONE - lfo_sel;
    {mod_amt, mod_lsb_unused} = {8'd0, inv} * {16'd0, depth_lat};
    gain_nxt                  = bypass_lat ? GAIN_ONE : (GAIN_ONE - mod_amt);
  end

  // Gain is always non-negative, so the product is floor(x*gain/2^16) and never grows
  always_comb begin
    x_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) x_ch = x_lat[i*DATA_WIDTH +: DATA_WIDTH];
    end
    x_ext              = {{16{x_ch[DATA_WIDTH-1]}}, x_ch};
    g_ext              = {{DATA_WIDTH{1'b0}}, gain};
    {y, frac_unused}   = x_ext * g_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lat      <= '0;
      depth_lat  <= '0;
      shape_lat  <= SHAPE_SINE;
      bypass_lat <= 1'b0;
      phase      <= '0;
      plat       <= '0;
      gain       <= '0;
      lfo_dbg    <= '0;
      ch         <= '0;
      audio_out  <= '0;
    end else begin
      if (accept) begin
        x_lat      <= audio_in;
        depth_lat  <= depth;
        shape_lat  <= shape_e'(shape);
        bypass_lat <= bypass;
        plat       <= ptop;
        phase      <= phase + fcw;
      end
      if (state == ST_GAIN) begin
        gain    <= gain_nxt;
        lfo_dbg <= lfo_sel;
        ch      <= '0;
      end
      if (state == ST_MAC) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch == CH_W'(i)) audio_out[i*DATA_WIDTH +: DATA_WIDTH] <= bypass_lat ? x_ch : y;
        end
        ch <= ch + 1'b1;
      end
    end
  end

  // A dropped frame in the same cycle as a clear must still leave the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (sample_valid && (state != ST_IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tremolo_multi.sv
// tb/tb_tremolo_multi.sv - scoreboard bench for tremolo_multi
module tb_tremolo_multi;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int PW  = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_valid;
  logic [NCH*DW-1:0] audio_in;
  logic [PW-1:0]    fcw;
  logic [7:0]       depth;
  logic [1:0]       shape;
  logic             bypass;
  logic             overrun_clr;
  logic [NCH*DW-1:0] audio_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic [15:0]      lfo_dbg;

  always #5 clk = ~clk;

  tremolo_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .PHASE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .fcw          (fcw),
    .depth        (depth),
    .shape        (shape),
    .bypass       (bypass),
    .overrun_clr  (overrun_clr),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .lfo_dbg      (lfo_dbg)
  );

  typedef struct {
    logic [31:0] out;
    logic [15:0] lfo;
    int          lt;
    int          ot;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [PW-1:0] phase_m = '0;

  task automatic check(input string tag, input longint obs, input longint exp, input int tol);
    total++;
    if (tol == 0) begin
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
    end else begin
      assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
      end
    end
  endtask

  function automatic int lfo_model(input logic [PW-1:0] p, input logic [1:0] sh);
    logic [16:0] t;
    logic [15:0] u;
    real v;
    t = p[PW-1 -: 17];
    case (sh)
      2'd0: begin
        v = 32767.0 * $sin(6.283185307179586 * real'(p[PW-1:14]) / 1024.0);
        return 32768 + ((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
      end
      2'd1: begin
        u = t[16] ? ~t[15:0] : t[15:0];
        return int'(u);
      end
      2'd2: return p[PW-1] ? 0 : 65535;
      default: return 65535;
    endcase
  endfunction

  function automatic int gain_model(input int lfo, input int d, input logic byp);
    return byp ? 65535 : 65535 - (((65535 - lfo) * d) >> 8);
  endfunction

  function automatic int y_model(input int x, input int g);
    longint pr;
    pr = longint'(x) * longint'(g);
    return int'(pr >>> 16);
  endfunction

  task automatic push_exp(input int x0, input int x1, input logic [PW-1:0] f, input int d,
                          input logic [1:0] sh, input logic byp, input int lt, input int ot);
    exp_t e;
    int lf;
    int g;
    lf    = lfo_model(phase_m, sh);
    g     = gain_model(lf, d, byp);
    e.lfo = 16'(lf);
    e.out[15:0]  = byp ? 16'(x0) : 16'(y_model(x0, g));
    e.out[31:16] = byp ? 16'(x1) : 16'(y_model(x1, g));
    e.lt  = lt;
    e.ot  = ot;
    sbq.push_back(e);
    phase_m = phase_m + f;
  endtask

  task automatic compare_pop();
    exp_t e;
    check("sb_depth", sbq.size(), 1, 0);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("ch0", signed'(audio_out[15:0]), signed'(e.out[15:0]), e.ot);
      check("ch1", signed'(audio_out[31:16]), signed'(e.out[31:16]), e.ot);
      check("lfo_dbg", lfo_dbg, e.lfo, e.lt);
    end
  endtask

  task automatic drive(input int x0, input int x1, input logic [PW-1:0] f, input int d,
                       input logic [1:0] sh, input logic byp);
    audio_in     = {16'(x1), 16'(x0)};
    fcw          = f;
    depth        = 8'(d);
    shape        = sh;
    bypass       = byp;
    sample_valid = 1'b1;
  endtask

  task automatic run_frame(input int x0, input int x1, input logic [PW-1:0] f, input int d,
                           input logic [1:0] sh, input logic byp, input int lt, input int ot,
                           input logic tm);
    int k;
    push_exp(x0, x1, f, d, sh, byp, lt, ot);
    @(negedge clk);
    if (tm) check("busy_k0", busy, 0, 0);
    drive(x0, x1, f, d, sh, byp);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      sample_valid = 1'b0;
      if (tm) begin
        check("busy_t", busy, (k <= 4), 0);
        check("ovalid_t", out_valid, (k == 5), 0);
      end
    end while (!out_valid && k < 20);
    check("latency", k, NCH + 3, 0);
    compare_pop();
    if (tm) begin
      @(negedge clk);
      check("ovalid_w", out_valid, 0, 0);
      check("busy_end", busy, 0, 0);
    end
  endtask

  task automatic ovr_frame(input logic with_clr);
    int n_ov;
    n_ov = 0;
    push_exp(7000, -5000, 24'h123456, 200, 2'd1, 1'b0, 0, 0);
    @(negedge clk);
    drive(7000, -5000, 24'h123456, 200, 2'd1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sample_valid = (k == 2);
      overrun_clr  = with_clr && (k == 2);
      if (k == 2) begin
        audio_in = 32'h7fff_8000;
        fcw      = 24'hfff000;
        shape    = 2'd2;
        depth    = 8'd17;
      end
      if (out_valid) begin
        n_ov++;
        compare_pop();
      end
    end
    check("ovr_frames", n_ov, 1, 0);
    check("ovr_flag", overrun, 1, 0);
  endtask

  task automatic clear_overrun();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0, 0);
  endtask

  initial begin
    int n_ov;
    rst = 1'b1;
    sample_valid = 1'b0;
    audio_in = '0;
    fcw = '0;
    depth = '0;
    shape = '0;
    bypass = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_audio", audio_out, 0, 0);
    check("rst_ovalid", out_valid, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_ovr", overrun, 0, 0);
    check("rst_lfo", lfo_dbg, 0, 0);
    rst = 1'b0;

    // depth 0 sine
    for (int n = 0; n < 4; n++) begin
      run_frame((n % 2) ? -12000 : 12000, (n % 2) ? 12000 : -12000, 24'd12345, 0, 2'd0, 1'b0,
                2, 0, 1'b0);
    end

    // square at full depth alternates every frame
    for (int n = 0; n < 3; n++) begin
      run_frame(16384, 16384, 24'h800000, 255, 2'd2, 1'b0, 0, 0, 1'b0);
    end
    run_frame(32767, -32768, 24'h000000, 255, 2'd2, 1'b1, 0, 0, 1'b0);
    run_frame(-20000, 300, 24'h000100, 128, 2'd3, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      run_frame(-32768, 25000, 24'h5a5a5a, 128, 2'd1, 1'b0, 0, 0, 1'b0);
    end

    // exact latency, strobe width and busy window
    run_frame(1000, -1000, 24'h2abcde, 100, 2'd1, 1'b0, 0, 0, 1'b1);

    // overrun: dropped frame, no phase advance, clear, set-wins-over-clear
    check("ovr_pre", overrun, 0, 0);
    ovr_frame(1'b0);
    run_frame(123, -456, 24'h010203, 200, 2'd1, 1'b0, 0, 0, 1'b0);
    clear_overrun();
    ovr_frame(1'b1);
    clear_overrun();

    // reset inside MAC abandons the frame
    @(negedge clk);
    drive(9000, -9000, 24'h345678, 255, 2'd0, 1'b0);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_audio", audio_out, 0, 0);
    check("mid_rst_lfo", lfo_dbg, 0, 0);
    check("mid_rst_busy", busy, 0, 0);
    check("mid_rst_ovalid", out_valid, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    phase_m = '0;
    n_ov = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check("rst_no_ovalid", n_ov, 0, 0);
    run_frame(20000, -20000, 24'h010000, 255, 2'd0, 1'b0, 0, 0, 1'b0);

    // full-cycle sine sweep with extreme inputs
    for (int n = 0; n < 256; n++) begin
      run_frame(32767, -32768, 24'h010000, 255, 2'd0, 1'b0, 2, 2, 1'b0);
      check("neg_sign", (signed'(audio_out[31:16]) <= 0), 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
